// File: rtl/alarm_bank_if.sv
// Edit / readback control bundle for alarm_bank.
// master drives buttons and selection; slave returns the selected time.
interface alarm_bank_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [SW-1:0] sel;
  logic          edit_en;
  logic [1:0]    field;
  logic          inc;
  logic          dec;
  logic          stop;
  logic          snooze;
  logic [7:0]    hr_out;
  logic [7:0]    min_out;
  logic [7:0]    sec_out;

  modport master (
    output sel, edit_en, field,
    output inc, dec, stop, snooze,
    input  hr_out, min_out, sec_out
  );

  modport slave (
    input  sel, edit_en, field,
    input  inc, dec, stop, snooze,
    output hr_out, min_out, sec_out
  );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm bank with per-channel ring/snooze FSM
// and in-place inc/dec editing of the stored alarm times.
module alarm_bank #(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            hr,
  input  logic [7:0]            min,
  input  logic [7:0]            sec,
  input  logic                  sec_tick,
  input  logic [NUM_ALARMS-1:0] arm,
  alarm_bank_if.slave           ctl,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_out
);
  localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [9:0] RING_LD = 10'(RING_SECS);
  localparam logic [9:0] SNZ_LD  = 10'(SNOOZE_SECS);
  localparam logic [3:0] SNZ_MAX = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } state_t;

  state_t     st_q   [NUM_ALARMS];
  state_t     st_d   [NUM_ALARMS];
  logic [9:0] cnt_q  [NUM_ALARMS];
  logic [9:0] cnt_d  [NUM_ALARMS];
  logic [3:0] snz_q  [NUM_ALARMS];
  logic [3:0] snz_d  [NUM_ALARMS];
  logic [7:0] ahr_q  [NUM_ALARMS];
  logic [7:0] ahr_d  [NUM_ALARMS];
  logic [7:0] amin_q [NUM_ALARMS];
  logic [7:0] amin_d [NUM_ALARMS];
  logic [7:0] asec_q [NUM_ALARMS];
  logic [7:0] asec_d [NUM_ALARMS];

  // Buttons: {snooze, stop, dec, inc}; sample then previous sample.
  logic [3:0] btn_q;
  logic [3:0] btn_p;
  logic [3:0] btn_e;
  logic       inc_e;
  logic       dec_e;
  logic       stop_e;
  logic       snz_e;
  logic       edit_step;

  assign btn_e  = btn_q & ~btn_p;
  assign inc_e  = btn_e[0];
  assign dec_e  = btn_e[1];
  assign stop_e = btn_e[2];
  assign snz_e  = btn_e[3];

  assign edit_step = ctl.edit_en
                   && (ctl.field != 2'd3)
                   && (inc_e ^ dec_e);

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] top
  );
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v,
    input logic [7:0] top
  );
    if (v == 8'h00) return top;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      snz_d[i]  = snz_q[i];
      ahr_d[i]  = ahr_q[i];
      amin_d[i] = amin_q[i];
      asec_d[i] = asec_q[i];
    end

    for (int i = 0; i < NUM_ALARMS; i++) begin
      logic is_sel;
      logic hit;
      is_sel = (ctl.sel == SW'(i));
      hit    = (hr == ahr_q[i])
            && (min == amin_q[i])
            && (sec == asec_q[i]);

      if (edit_step && is_sel) begin
        unique case (ctl.field)
          2'd0: ahr_d[i] = inc_e ? bcd_inc(ahr_q[i], 8'h23)
                                 : bcd_dec(ahr_q[i], 8'h23);
          2'd1: amin_d[i] = inc_e ? bcd_inc(amin_q[i], 8'h59)
                                  : bcd_dec(amin_q[i], 8'h59);
          2'd2: asec_d[i] = inc_e ? bcd_inc(asec_q[i], 8'h59)
                                  : bcd_dec(asec_q[i], 8'h59);
          default: ;
        endcase
      end

      if (!arm[i]) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
        snz_d[i] = '0;
      end else if (edit_step && is_sel) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
        snz_d[i] = '0;
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (sec_tick && hit) begin
              st_d[i]  = RINGING;
              cnt_d[i] = RING_LD;
              snz_d[i] = '0;
            end
          end
          RINGING: begin
            if (stop_e && is_sel) begin
              st_d[i]  = IDLE;
              cnt_d[i] = '0;
            end else if (snz_e && is_sel) begin
              // Out of snoozes: the request ends the ring event.
              if (snz_q[i] < SNZ_MAX) begin
                st_d[i]  = SNOOZED;
                snz_d[i] = snz_q[i] + 4'd1;
                cnt_d[i] = SNZ_LD;
              end else begin
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
              end
            end else if (sec_tick) begin
              if (cnt_q[i] <= 10'd1) begin
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] - 10'd1;
              end
            end
          end
          SNOOZED: begin
            if (stop_e && is_sel) begin
              st_d[i]  = IDLE;
              cnt_d[i] = '0;
            end else if (sec_tick) begin
              if (cnt_q[i] <= 10'd1) begin
                st_d[i]  = RINGING;
                cnt_d[i] = RING_LD;
              end else begin
                cnt_d[i] = cnt_q[i] - 10'd1;
              end
            end
          end
          default: begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= '0;
      btn_p <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]   <= IDLE;
        cnt_q[i]  <= '0;
        snz_q[i]  <= '0;
        ahr_q[i]  <= '0;
        amin_q[i] <= '0;
        asec_q[i] <= '0;
      end
    end else begin
      btn_q <= {ctl.snooze, ctl.stop, ctl.dec, ctl.inc};
      btn_p <= btn_q;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        snz_q[i]  <= snz_d[i];
        ahr_q[i]  <= ahr_d[i];
        amin_q[i] <= amin_d[i];
        asec_q[i] <= asec_d[i];
      end
    end
  end

  always_comb begin
    ringing     = '0;
    ctl.hr_out  = 8'h00;
    ctl.min_out = 8'h00;
    ctl.sec_out = 8'h00;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      ringing[i] = (st_q[i] == RINGING);
      if (ctl.sel == SW'(i)) begin
        ctl.hr_out  = ahr_q[i];
        ctl.min_out = amin_q[i];
        ctl.sec_out = asec_q[i];
      end
    end
  end

  assign alarm_out = |ringing;
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel successor to the single alarm comparator: holds `NUM_ALARMS` independently armed BCD alarm times, compares them against the clock-keeping block's BCD time once per second, and runs a per-channel ring / snooze / timeout state machine. Sits between the timekeeping counter (which supplies `hr`/`min`/`sec` and `sec_tick`) and the display/buzzer logic. Alarm times are edited in place with edge-detected inc/dec buttons that wrap in BCD.

## Interface
Parameters:
- `NUM_ALARMS`, 4: number of alarm channels (1-8).
- `RING_SECS`, 60: seconds a channel rings before auto-stop (1-255).
- `SNOOZE_SECS`, 300: snooze length in seconds (1-1023).
- `MAX_SNOOZE`, 3: snoozes allowed per ring event (0-15); further snooze requests act as stop.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `hr`, `min`, `sec` in 8 each: current time, packed BCD (00-23 / 00-59 / 00-59).
- `sec_tick` in 1: one-cycle pulse, asserted in the cycle the time inputs hold a new second.
- `arm` in `NUM_ALARMS`: level; bit i high = channel i armed.
- `sel` in `$clog2(NUM_ALARMS)` (min 1): channel selected for edit/readback/stop/snooze.
- `edit_en` in 1: editing enabled for selected channel.
- `field` in 2: 0 = hour, 1 = minute, 2 = second, 3 = none.
- `inc`, `dec` in 1: button levels, active-high; edge-detected internally.
- `stop`, `snooze` in 1: levels, active-high; edge-detected internally; apply to channel `sel`.
- `ringing` out `NUM_ALARMS`: channel in RINGING.
- `alarm_out` out 1: OR of `ringing`.
- `hr_out`, `min_out`, `sec_out` out 8 each: stored alarm time of channel `sel` (combinational from registers).

## Operation
- Button edges: `inc`, `dec`, `stop`, `snooze` each registered once; action on rising edge (input high, previous sample low). One step per press.
- Editing (when `edit_en`, `field` != 3): inc edge -> selected field +1 BCD, 23->00 (hour), 59->00 (min/sec); dec edge -> -1 BCD, 00->23 / 00->59. Inc and dec edges in same cycle -> no change. Any edit step also forces the selected channel to IDLE and clears its snooze count.
- Per-channel FSM, states IDLE, RINGING, SNOOZED:
  - IDLE -> RINGING: `sec_tick` high, `arm[i]` high, `hr/min/sec` equal stored time. Load ring counter with `RING_SECS`, snooze count 0.
  - RINGING -> IDLE: stop edge on `sel`==i; or ring counter reaches 0 (decremented on each `sec_tick`).
  - RINGING -> SNOOZED: snooze edge on `sel`==i and snooze count < `MAX_SNOOZE`; increment count, load snooze counter with `SNOOZE_SECS`. If count == `MAX_SNOOZE`, snooze acts as stop.
  - SNOOZED -> RINGING: snooze counter reaches 0 (decremented per `sec_tick`); reload ring counter.
  - SNOOZED -> IDLE: stop edge on `sel`==i.
  - Any state -> IDLE: `arm[i]` low (checked every cycle, highest priority after reset).
- Priority per channel: reset > disarm > edit > stop > snooze > counter expiry > time match.
- Time match ignored in RINGING/SNOOZED (no retrigger).
- Comparison is full 8-bit equality; invalid BCD inputs simply never match.

## Timing
- Reset: all stored times 00:00:00, all channels IDLE, counters and snooze counts 0, edge registers 0; `ringing`=0, `alarm_out`=0, `hr_out/min_out/sec_out`=00.
- Match latency: `ringing[i]` rises the cycle after the matching `sec_tick`.
- Button latency: rising input at cycle n -> effect visible at n+1 (edge reg) ... state/setting updated at end of cycle n+1, outputs at n+2 (not counting external synchronisers).
- Ring duration: exactly `RING_SECS` `sec_tick`s after entry, drop in cycle after the final tick.
- Snooze duration: re-ring in cycle after the `SNOOZE_SECS`-th `sec_tick` following snooze entry.
- `hr_out` etc. follow `sel` combinationally; change one cycle after an edit step.
- Held buttons produce exactly one action regardless of length.

## Test plan
- Reset, set ch0 to 07:30:00 via field=0 seven inc edges, field=1 thirty inc edges -> `hr_out`=07, `min_out`=30; arm[0]=1, drive 07:29:59 then 07:30:00 with `sec_tick` -> `ringing`=0001 next cycle, `alarm_out`=1.
- Wrap: hour 23 + inc -> 00; minute 00 + dec -> 59; inc+dec same cycle -> unchanged; 50-cycle inc hold -> +1 only.
- Ringing ch0, no input, `RING_SECS`=60 -> drops after 60 ticks; stop edge at tick 10 -> drops next cycle.
- Snooze: `SNOOZE_SECS`=5, `MAX_SNOOZE`=2 -> snooze twice, re-ring each 5 ticks later; third snooze edge -> IDLE.
- Two channels same time, both armed -> `ringing`=0011; stop with `sel`=1 -> `ringing`=0001; drop `arm[0]` -> 0000 next cycle.
- `reset` asserted mid-ring and mid-snooze -> all outputs 0 next cycle, stored times 00:00:00.
